// File: rtl/clk125_to_10_pkg.sv
// Shared constants and helpers for the 125 MHz -> 10 MHz fractional divider.
package clk_div_pkg;

    localparam int CLK_IN_HZ = 125_000_000;
    localparam int CLK10_HZ  = 10_000_000;
    localparam int DEF_DIV_N = 25;
    localparam int DEF_DIV_M = 2;

    // Accumulator width able to hold any residue below n plus one guard bit.
    function automatic int acc_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/clk125_to_10_if.sv
// Divided-clock output bundle; clk10_stb exists only when CLK10_STROBE_EN is defined.
interface clk125_to_10_if;

    logic clk10;
`ifdef CLK10_STROBE_EN
    logic clk10_stb;
`endif

`ifdef CLK10_STROBE_EN
    modport master (output clk10, output clk10_stb);
    modport slave  (input  clk10, input  clk10_stb);
`else
    modport master (output clk10);
    modport slave  (input  clk10);
`endif

endinterface

// File: rtl/clk125_to_10_frac_acc.sv
// Modulo-MOD phase accumulator advancing by STEP; wrap_o flags that the next edge wraps.
module frac_acc
    import clk_div_pkg::*;
#(
    parameter int STEP = 2 * DEF_DIV_M,
    parameter int MOD  = DEF_DIV_N
) (
    input  logic clk,
    input  logic rst,
    output logic wrap_o
);

    localparam int ACC_W = acc_width(MOD);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;

    // Sum carries one extra bit so acc + STEP never overflows before the compare.
    always_comb begin
        sum    = {1'b0, acc_q} + (ACC_W+1)'(STEP);
        diff   = sum - (ACC_W+1)'(MOD);
        wrap_o = (sum >= (ACC_W+1)'(MOD));
        acc_d  = wrap_o ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/clk125_to_10.sv
// Fractional clock divider producing DIV_M clk10 periods per DIV_N input cycles.
// Define CLK10_STROBE_EN to add clk10_stb, a one-cycle pulse after each clk10 rise.
module clk125_to_10
    import clk_div_pkg::*;
#(
    parameter int DIV_N = DEF_DIV_N,
    parameter int DIV_M = DEF_DIV_M
) (
    input  logic           clk,
    input  logic           rst,
    clk125_to_10_if.master bus
);

    generate
        if (DIV_M == 0 || DIV_N < 4 * DIV_M) begin : g_bad_ratio
            $error("clk125_to_10: need DIV_M > 0 and DIV_N >= 4*DIV_M");
        end
    endgenerate

    logic wrap;
    logic clk10_q, clk10_d;

    frac_acc #(
        .STEP (2 * DIV_M),
        .MOD  (DIV_N)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .wrap_o (wrap)
    );

    always_comb begin
        clk10_d = clk10_q ^ wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk10_q <= 1'b0;
        end else begin
            clk10_q <= clk10_d;
        end
    end

    assign bus.clk10 = clk10_q;

`ifdef CLK10_STROBE_EN
    logic stb_q, stb_d;

    // Pulse on the same edge that clk10 goes 0->1, so it is high for that cycle.
    always_comb begin
        stb_d = wrap & ~clk10_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= stb_d;
        end
    end

    assign bus.clk10_stb = stb_q;
`endif

endmodule

// File: tb/tb_clk125_to_10.sv
// Directed bench for clk125_to_10: reset hold, edge placement, async reset, long-run rate.
module tb_clk125_to_10;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    clk125_to_10_if bus_a ();
    clk125_to_10_if bus_b ();

    clk125_to_10 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    // Alternate ratio 20/2: constant 10-cycle period, 5 high / 5 low.
    clk125_to_10 #(.DIV_N(20), .DIV_M(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk(input string tag, input int e, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, e, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Hand-written schedule: within each 25-edge frame clk10 is high on edges 7..12 and 19..24.
    function automatic logic exp_clk10(input int e);
        int pos;
        pos = (e - 1) % 25 + 1;
        return ((pos >= 7 && pos <= 12) || (pos >= 19 && pos <= 24));
    endfunction

    function automatic logic exp_stb(input int e);
        int pos;
        pos = (e - 1) % 25 + 1;
        return (pos == 7 || pos == 19);
    endfunction

    task automatic chk_edge(input string tag, input int e);
        chk(tag, e, bus_a.clk10, exp_clk10(e));
`ifdef CLK10_STROBE_EN
        chk({tag, "_stb"}, e, bus_a.clk10_stb, exp_stb(e));
`endif
    endtask

    initial begin
        int   rises, bad_a, bad_b;
        int   last_rise_a, last_rise_b;
        logic prev_a, prev_b;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;

        // Reset hold
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_hold", i, bus_a.clk10, 1'b0);
`ifdef CLK10_STROBE_EN
            chk("reset_hold_stb", i, bus_a.clk10_stb, 1'b0);
`endif
        end

        // Cold start edge placement
        release_rst();
        for (int e = 1; e <= 57; e++) begin
            step();
            chk_edge("cold", e);
        end

        // Edge 57 raised clk10; assert reset mid-cycle with no clock edge
        chk("high_before_async", 57, bus_a.clk10, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_drop", 57, bus_a.clk10, 1'b0);
        step();
        release_rst();

        // Mid-run reset at edge 16 for 3 cycles
        for (int e = 1; e <= 16; e++) begin
            step();
            chk_edge("pre_mid", e);
        end
        rst = 1'b0;
        #1;
        chk("mid_assert", 16, bus_a.clk10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_hold", i, bus_a.clk10, 1'b0);
        end
        release_rst();
        for (int e = 1; e <= 25; e++) begin
            step();
            chk_edge("restart", e);
        end

        // Long run from a fresh release
        rst = 1'b0;
        step();
        release_rst();
        rises = 0;
        bad_a = 0;
        bad_b = 0;
        last_rise_a = -1;
        last_rise_b = -1;
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int e = 1; e <= 25000; e++) begin
            step();
            if (bus_a.clk10 && !prev_a) begin
                rises++;
                if (last_rise_a >= 0 && (e - last_rise_a) != 12 && (e - last_rise_a) != 13)
                    bad_a++;
                last_rise_a = e;
            end
            if (!bus_a.clk10 && prev_a) begin
                if ((e - last_rise_a) != 6 && (e - last_rise_a) != 7)
                    bad_a++;
            end
            if (bus_b.clk10 && !prev_b) begin
                if (last_rise_b >= 0 && (e - last_rise_b) != 10)
                    bad_b++;
                last_rise_b = e;
            end
            if (!bus_b.clk10 && prev_b) begin
                if ((e - last_rise_b) != 5)
                    bad_b++;
            end
            prev_a = bus_a.clk10;
            prev_b = bus_b.clk10;
        end
        chk_int("long_rises", rises, 2000);
        chk_int("long_bad_period_high", bad_a, 0);
        chk_int("alt_bad_period_high", bad_b, 0);
        chk_int("alt_first_rise", (last_rise_b >= 0) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
